// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-side load/store sequencer in front of memoryController
module mem_access_unit #(
    parameter int S        = 32,
    parameter int V        = 192,
    parameter int TAG_W    = 4,
    parameter int RD_LAT   = 1,
    parameter int VEC_SPAN = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic             req_vec,
    input  logic [S-1:0]     req_addr,
    input  logic [V-1:0]     req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_we,
    output logic             mem_vecop,
    output logic [S-1:0]     mem_address,
    output logic [V-1:0]     mem_wd,
    input  logic [V-1:0]     mem_rd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [V-1:0]     rsp_rdata,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_fault,
    output logic             busy,
    output logic [7:0]       fault_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [S:0] ROM_LO  = (S+1)'(1000);
    localparam logic [S:0] ROM_HI  = (S+1)'(30999);
    localparam logic [S:0] RAM_HI  = (S+1)'(61014);
    localparam logic [S:0] SPAN_M1 = (S+1)'(VEC_SPAN - 1);
    localparam logic [3:0] LAT_M1  = 4'(RD_LAT - 1);

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic               vec_q, vec_d;
    logic [S-1:0]       addr_q, addr_d;
    logic [V-1:0]       wdata_q, wdata_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [1:0]         fault_q, fault_d;
    logic [V-1:0]       rdata_q, rdata_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         fault_cnt_q, fault_cnt_d;

    logic [S:0]         addr_x;
    logic [S:0]         vec_end;
    logic [S:0]         region_end;
    logic [1:0]         fault_calc;

    // One extra bit keeps addr+span from wrapping near the top of the address space.
    always_comb begin
        addr_x     = {1'b0, req_addr};
        vec_end    = addr_x + SPAN_M1;
        region_end = (addr_x <= ROM_HI) ? ROM_HI : RAM_HI;
        fault_calc = 2'd0;
        if (addr_x < ROM_LO || addr_x > RAM_HI) begin
            fault_calc = 2'd1;
        end else if (req_we && addr_x <= ROM_HI) begin
            fault_calc = 2'd2;
        end else if (req_vec && vec_end > region_end) begin
            fault_calc = 2'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        vec_d       = vec_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        fault_cnt_d = fault_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    vec_d   = req_vec;
                    addr_d  = req_addr;
                    tag_d   = req_tag;
                    wdata_d = req_vec ? req_wdata : {{(V-S){1'b0}}, req_wdata[S-1:0]};
                    fault_d = fault_calc;
                    rdata_d = '0;
                    if (fault_calc != 2'd0) begin
                        state_d = RESP;
                        if (fault_cnt_q != 8'hFF) begin
                            fault_cnt_d = fault_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (we_q) begin
                        rdata_d = '0;
                    end else if (vec_q) begin
                        rdata_d = mem_rd;
                    end else begin
                        rdata_d = {{(V-S){1'b0}}, mem_rd[S-1:0]};
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            vec_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tag_q       <= '0;
            fault_q     <= 2'd0;
            rdata_q     <= '0;
            cnt_q       <= 4'd0;
            fault_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            vec_q       <= vec_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag_q       <= tag_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    // Controller-facing signals are gated flop outputs, so they stay put for the whole access.
    logic mem_active;
    assign mem_active  = (state_q == ISSUE) || (state_q == WAIT);
    assign mem_we      = (state_q == ISSUE) && we_q;
    assign mem_vecop   = mem_active && vec_q;
    assign mem_address = mem_active ? addr_q : '0;
    assign mem_wd      = mem_active ? wdata_q : '0;

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_tag   = tag_q;
    assign rsp_fault = fault_q;
    assign busy      = (state_q != IDLE);
    assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int RD_LAT = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic         req_vec;
    logic [31:0]  req_addr;
    logic [191:0] req_wdata;
    logic [3:0]   req_tag;
    logic         mem_we;
    logic         mem_vecop;
    logic [31:0]  mem_address;
    logic [191:0] mem_wd;
    logic [191:0] mem_rd;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [191:0] rsp_rdata;
    logic [3:0]   rsp_tag;
    logic [1:0]   rsp_fault;
    logic         busy;
    logic [7:0]   fault_cnt;

    mem_access_unit #(.S(32), .V(192), .TAG_W(4), .RD_LAT(RD_LAT), .VEC_SPAN(24)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_vec(req_vec),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .mem_we(mem_we), .mem_vecop(mem_vecop), .mem_address(mem_address), .mem_wd(mem_wd),
        .mem_rd(mem_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
        .rsp_fault(rsp_fault), .busy(busy), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic bit [191:0] dflt(input int unsigned a);
        if (a == 1005) return {160'b0, 32'hDEADBEEF};
        return {6{a ^ 32'h5A3C0000}};
    endfunction

    // Memory behind the controller: written only by DUT stores.
    bit [191:0] env_mem [0:65535];
    bit         env_wr  [0:65535];
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_address[15:0]] <= mem_wd;
            env_wr[mem_address[15:0]]  <= 1'b1;
        end
    end
    always @(negedge clk) begin
        mem_rd <= env_wr[mem_address[15:0]] ? env_mem[mem_address[15:0]] : dflt(mem_address);
    end

    // Reference model state.
    bit [191:0] ref_mem [0:65535];
    bit         ref_wr  [0:65535];
    int         exp_fcnt = 0;

    function automatic bit [1:0] model_fault(input bit we, input bit vec, input int unsigned a);
        longint la = longint'(a);
        longint rend;
        if (la < 1000 || la > 61014) return 2'd1;
        if (we && la <= 30999) return 2'd2;
        rend = (la <= 30999) ? 30999 : 61014;
        if (vec && la + 23 > rend) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit [191:0] model_rdata(input bit we, input bit vec, input int unsigned a);
        bit [191:0] w;
        if (we || model_fault(we, vec, a) != 2'd0) return '0;
        w = ref_wr[a[15:0]] ? ref_mem[a[15:0]] : dflt(a);
        return vec ? w : {160'b0, w[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    int unsigned addr_c [1:3];

    task automatic run_req(input bit we, input bit vec, input int unsigned a, input bit [191:0] wd,
                           input bit [3:0] tag, input string nm, output bit [1:0] act_fault);
        bit [1:0]   ef;
        bit [191:0] er;
        int         elat;
        int         lat;
        int         pulses;
        bit         got;
        ef   = model_fault(we, vec, a);
        er   = model_rdata(we, vec, a);
        elat = (ef != 2'd0) ? 1 : RD_LAT + 2;
        if (ef != 2'd0) begin
            if (exp_fcnt < 255) exp_fcnt++;
        end else if (we) begin
            ref_mem[a[15:0]] = vec ? wd : {160'b0, wd[31:0]};
            ref_wr[a[15:0]]  = 1'b1;
        end
        @(negedge clk);
        chk({nm, " req_ready"}, 192'(req_ready), 192'(1));
        req_valid = 1'b1; req_we = we; req_vec = vec; req_addr = a; req_wdata = wd; req_tag = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;
        pulses = 0; lat = 0; got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (c <= 3) addr_c[c] = mem_address;
            if (mem_we) pulses++;
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk({nm, " latency"}, 192'(lat), 192'(elat));
        chk({nm, " fault"}, 192'(rsp_fault), 192'(ef));
        chk({nm, " rdata"}, rsp_rdata, er);
        chk({nm, " tag"}, 192'(rsp_tag), 192'(tag));
        chk({nm, " we_pulses"}, 192'(pulses), 192'((ef == 2'd0 && we) ? 1 : 0));
        chk({nm, " fault_cnt"}, 192'(fault_cnt), 192'(exp_fcnt));
        act_fault = rsp_fault;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        bit          we;
        bit          vec;
        int unsigned addr;
        bit [191:0]  wdata;
        bit [1:0]    exp_fault;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [14];
        bit [1:0]    f;
        bit [191:0]  hold_exp;
        int unsigned ra;
        bit [191:0]  rw;
        bit          got;

        tbl[0]  = '{1'b1, 1'b1, 31000, {24{8'hA5}}, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 31000, 192'd0, 2'd0};
        tbl[2]  = '{1'b1, 1'b0, 2000, 192'hFEED, 2'd2};
        tbl[3]  = '{1'b0, 1'b0, 500, 192'd0, 2'd1};
        tbl[4]  = '{1'b0, 1'b1, 60991, 192'd0, 2'd0};
        tbl[5]  = '{1'b0, 1'b1, 60992, 192'd0, 2'd3};
        tbl[6]  = '{1'b0, 1'b0, 61015, 192'd0, 2'd1};
        tbl[7]  = '{1'b0, 1'b0, 30999, 192'd0, 2'd0};
        tbl[8]  = '{1'b1, 1'b0, 31000, {160'hFFFF, 32'h12345678}, 2'd0};
        tbl[9]  = '{1'b0, 1'b0, 61014, 192'd0, 2'd0};
        tbl[10] = '{1'b0, 1'b1, 30976, 192'd0, 2'd0};
        tbl[11] = '{1'b0, 1'b1, 30977, 192'd0, 2'd3};
        tbl[12] = '{1'b1, 1'b1, 999, 192'd0, 2'd1};
        tbl[13] = '{1'b1, 1'b1, 30990, 192'd0, 2'd2};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0;
        req_addr = '0; req_wdata = '0; req_tag = '0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst req_ready", 192'(req_ready), 192'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 192'(req_ready), 192'(1));
        chk("reset busy", 192'(busy), 192'(0));
        chk("reset rsp_valid", 192'(rsp_valid), 192'(0));
        chk("reset mem_we", 192'(mem_we), 192'(0));
        chk("reset mem_address", 192'(mem_address), 192'(0));
        chk("reset fault_cnt", 192'(fault_cnt), 192'(0));

        run_req(1'b0, 1'b0, 1005, 192'd0, 4'd5, "rom_load", f);
        chk("rom_load addr c1", 192'(addr_c[1]), 192'(1005));
        chk("rom_load addr c2", 192'(addr_c[2]), 192'(1005));
        chk("rom_load addr c3", 192'(addr_c[3]), 192'(0));

        for (int i = 0; i < 14; i++) begin
            run_req(tbl[i].we, tbl[i].vec, tbl[i].addr, tbl[i].wdata, 4'(i), $sformatf("tbl%0d", i), f);
            chk($sformatf("tbl%0d fault_const", i), 192'(f), 192'(tbl[i].exp_fault));
        end

        // Response held off for five cycles while another request is presented.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_vec = 1'b0; req_addr = 40000; req_tag = 4'd9;
        hold_exp = model_rdata(1'b0, 1'b0, 40000);
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("hold rsp arrives", 192'(got), 192'(1));
        req_valid = 1'b1; req_addr = 500; req_tag = 4'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold rsp_valid", 192'(rsp_valid), 192'(1));
            chk("hold rsp_rdata", rsp_rdata, hold_exp);
            chk("hold rsp_tag", 192'(rsp_tag), 192'(9));
            chk("hold req_ready", 192'(req_ready), 192'(0));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("release busy", 192'(busy), 192'(0));
        chk("release req_ready", 192'(req_ready), 192'(1));
        chk("release fault_cnt", 192'(fault_cnt), 192'(exp_fcnt));
        run_req(1'b0, 1'b0, 40004, 192'd0, 4'd10, "after_hold", f);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: ra = $urandom_range(0, 1200);
                1: ra = $urandom_range(1000, 31100);
                2: ra = $urandom_range(30960, 31010);
                3: ra = $urandom_range(31000, 61020);
                4: ra = $urandom_range(60980, 61020);
                default: ra = 31000 + 32 * $urandom_range(0, 7);
            endcase
            rw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw, 4'($urandom), "rnd", f);
        end

        // Reset while the access sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_vec = 1'b0; req_addr = 40008; req_tag = 4'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wait busy", 192'(busy), 192'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort mem_we", 192'(mem_we), 192'(0));
        chk("abort mem_address", 192'(mem_address), 192'(0));
        chk("abort rsp_valid", 192'(rsp_valid), 192'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("abort req_ready", 192'(req_ready), 192'(1));
        chk("abort fault_cnt", 192'(fault_cnt), 192'(0));
        exp_fcnt = 0;

        for (int i = 0; i < 256; i++) begin
            run_req(1'b0, 1'b0, 500, 192'd0, 4'(i), "sat", f);
        end
        chk("sat fault_cnt", 192'(fault_cnt), 192'(255));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-side access sequencer between the execute stage and memoryController.
- Accepts one scalar/vector load or store per valid/ready handshake and range-checks it against the unified map: instr 0..999, ROM 1000..30999, RAM 31000..61014.
- Drives the controller's address/we/VecOp/wd with stable, registered values for the whole access, waits a fixed latency, captures rd and returns a tagged response.
- Illegal accesses never reach memory; they are reported as faults.

Parameters:
- S, 32, scalar/address width
- V, 192, vector data width
- TAG_W, 4, request tag width
- RD_LAT, 1, cycles the address is held before rd is sampled (legal range 1..15)
- VEC_SPAN, 24, addresses covered by one vector access

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept
- req_we  in  1  1=store, 0=load
- req_vec  in  1  1=vector (V bits), 0=scalar (S bits)
- req_addr  in  S  byte/word address in unified map
- req_wdata  in  V  store data; scalar uses [S-1:0]
- req_tag  in  TAG_W  returned unchanged
- mem_we  out  1  to controller we
- mem_vecop  out  1  to controller VecOp
- mem_address  out  S  to controller address
- mem_wd  out  V  to controller wd
- mem_rd  in  V  from controller rd
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  V  load data
- rsp_tag  out  TAG_W  tag of request
- rsp_fault  out  2  0 ok, 1 unmapped/instr region, 2 store to ROM, 3 vector crosses region end
- busy  out  1  state != IDLE
- fault_cnt  out  8  saturating fault counter

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. All registers update on the rising edge of clk.
- Reset:
  - State goes to IDLE; all outputs are 0 (req_ready=0 during the rst cycle, 1 afterwards in IDLE); fault_cnt=0.
  - rst mid-access aborts immediately: mem_we=0 and mem_address=0 from the next cycle; any pending response is dropped.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1; mem_* all 0.
  - On req_valid: latch request and compute fault code from the latched address:
    - addr<1000 or addr>61014 -> 1
    - store with 1000<=addr<=30999 -> 2
    - vector with addr+VEC_SPAN-1 beyond its region end -> 3
    - Priority 1 > 2 > 3.
  - fault!=0 -> go to RESP with rsp_rdata=0, fault_cnt+1 (saturates at 255). Memory is untouched.
  - fault==0 -> go to ISSUE.
- ISSUE (1 cycle):
  - Drive mem_address=addr, mem_vecop=vec, mem_wd=wdata (scalar: upper V-S bits forced 0).
  - mem_we=req_we for this single cycle only. Then go to WAIT.
- WAIT (RD_LAT cycles, internal 4-bit counter):
  - mem_address, mem_vecop and mem_wd are held; mem_we=0.
  - On the last WAIT edge, capture rsp_rdata: load+vector -> mem_rd; load+scalar -> {0, mem_rd[S-1:0]}; store -> 0.
  - Then go to RESP.
- RESP:
  - mem_* return to 0; rsp_valid=1.
  - rsp_rdata, rsp_tag and rsp_fault are stable until rsp_valid && rsp_ready, then go to IDLE.
  - Accept is not possible in the same cycle (req_ready=0 outside IDLE).
- Latency:
  - Legal access: accept edge -> rsp_valid high RD_LAT+2 cycles later.
  - Faulting access: 1 cycle later.
  - Throughput is one access per RD_LAT+3 cycles with rsp_ready tied high.
- Boundaries:
  - addr=30999 scalar load is legal.
  - addr=31000 store is legal.
  - addr=61014 scalar is legal.
  - Vector at 60991 (end 61014) is legal; vector at 60992 gives fault 3.
  - Vector at 30976 (end 30999) is legal; vector at 30977 gives fault 3.
- Simultaneous rst and req_valid: rst wins and the request is not accepted.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Reset, then scalar load addr=1005 with ROM word 0xDEADBEEF, RD_LAT=1 -> mem_address=1005 for cycles 1-2, rsp_valid at cycle 3, rsp_rdata=0x...0DEADBEEF, fault 0, tag echoed.
- Vector store addr=31000 data=0xA5 repeated, then vector load addr=31000 -> mem_we high for exactly one cycle; load returns the identical 192-bit pattern.
- Store addr=2000 -> rsp_fault=2 one cycle after accept, mem_we never asserted, fault_cnt=1. Load addr=500 -> fault 1, fault_cnt=2.
- Vector load at 60991 -> ok. Vector load at 60992 -> fault 3. Scalar load at 61015 -> fault 1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, new req_valid ignored; release -> IDLE, next request accepted the cycle after.
- Assert rst during WAIT -> next cycle mem_we=0, mem_address=0, rsp_valid=0, req_ready=1 after rst drops. Then 256 faulting requests -> fault_cnt saturates at 255.
